// File: rtl/mem_access_arbiter_pkg.sv
// Shared constants for the memory-access path: opcodes, arbiter
// state encoding and active-low strobe levels.
package mem_access_arbiter_pkg;

    localparam int unsigned XLEN = 16;

    localparam logic [3:0] OP_LW    = 4'h8;
    localparam logic [3:0] OP_LW_SP = 4'h9;
    localparam logic [3:0] OP_SW    = 4'hA;
    localparam logic [3:0] OP_SW_SP = 4'hB;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ACCESS,
        ST_RD_DONE,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD
    } arb_state_e;

    typedef enum logic {
        GNT_IF,
        GNT_DM
    } arb_port_e;

    localparam logic STB_ON  = 1'b0;
    localparam logic STB_OFF = 1'b1;

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_SW) || (op == OP_SW_SP);
    endfunction

endpackage

// File: rtl/mem_access_arbiter_if.sv
// Fetch port, data port and shared SRAM bus of the memory arbiter.
// The slave modport is the arbiter's view; master is the core/SRAM side.
interface mem_access_arbiter_if;
    import mem_access_arbiter_pkg::*;

    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic [XLEN-1:0] if_rdata;
    logic            if_ack;

    logic            dm_req;
    logic            dm_we;
    logic [XLEN-1:0] dm_addr;
    logic [XLEN-1:0] dm_wdata;
    logic [XLEN-1:0] dm_rdata;
    logic            dm_ack;

    logic            stall_if;

    logic [XLEN-1:0] sram_addr;
    logic [XLEN-1:0] sram_dq_o;
    logic            sram_dq_oe;
    logic [XLEN-1:0] sram_dq_i;
    logic            sram_ce_n;
    logic            sram_oe_n;
    logic            sram_we_n;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
        input  sram_dq_i,
        output if_rdata, if_ack, dm_rdata, dm_ack, stall_if,
        output sram_addr, sram_dq_o, sram_dq_oe,
        output sram_ce_n, sram_oe_n, sram_we_n
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
        output sram_dq_i,
        input  if_rdata, if_ack, dm_rdata, dm_ack, stall_if,
        input  sram_addr, sram_dq_o, sram_dq_oe,
        input  sram_ce_n, sram_oe_n, sram_we_n
    );

endinterface

// File: rtl/mem_access_arbiter.sv
// Single-port SRAM arbiter between instruction fetch and data access.
// Data wins ties; every strobe and ack comes straight from a flop.
module mem_access_arbiter
    import mem_access_arbiter_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    mem_access_arbiter_if.slave bus
);

    arb_state_e      state_q;
    arb_port_e       port_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic            ce_n_q;
    logic            oe_n_q;
    logic            we_n_q;
    logic            dq_oe_q;
    logic            if_ack_q;
    logic            dm_ack_q;
    logic [XLEN-1:0] if_rdata_q;
    logic [XLEN-1:0] dm_rdata_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            port_q     <= GNT_IF;
            addr_q     <= '0;
            wdata_q    <= '0;
            ce_n_q     <= STB_OFF;
            oe_n_q     <= STB_OFF;
            we_n_q     <= STB_OFF;
            dq_oe_q    <= 1'b0;
            if_ack_q   <= 1'b0;
            dm_ack_q   <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.dm_req) begin
                        port_q  <= GNT_DM;
                        addr_q  <= bus.dm_addr;
                        wdata_q <= bus.dm_wdata;
                        ce_n_q  <= STB_ON;
                        if (bus.dm_we) begin
                            dq_oe_q <= 1'b1;
                            state_q <= ST_WR_SETUP;
                        end else begin
                            oe_n_q  <= STB_ON;
                            state_q <= ST_RD_ACCESS;
                        end
                    end else if (bus.if_req) begin
                        port_q  <= GNT_IF;
                        addr_q  <= bus.if_addr;
                        ce_n_q  <= STB_ON;
                        oe_n_q  <= STB_ON;
                        state_q <= ST_RD_ACCESS;
                    end
                end
                ST_RD_ACCESS: begin
                    // SRAM word is sampled here, at the end of the access cycle
                    ce_n_q <= STB_OFF;
                    oe_n_q <= STB_OFF;
                    if (port_q == GNT_DM) begin
                        dm_rdata_q <= bus.sram_dq_i;
                        dm_ack_q   <= 1'b1;
                    end else begin
                        if_rdata_q <= bus.sram_dq_i;
                        if_ack_q   <= 1'b1;
                    end
                    state_q <= ST_RD_DONE;
                end
                ST_RD_DONE: begin
                    state_q <= ST_IDLE;
                end
                ST_WR_SETUP: begin
                    we_n_q  <= STB_ON;
                    state_q <= ST_WR_PULSE;
                end
                ST_WR_PULSE: begin
                    we_n_q   <= STB_OFF;
                    dm_ack_q <= 1'b1;
                    state_q  <= ST_WR_HOLD;
                end
                ST_WR_HOLD: begin
                    ce_n_q  <= STB_OFF;
                    dq_oe_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.if_rdata   = if_rdata_q;
    assign bus.if_ack     = if_ack_q;
    assign bus.dm_rdata   = dm_rdata_q;
    assign bus.dm_ack     = dm_ack_q;
    assign bus.stall_if   = bus.if_req & ~if_ack_q;
    assign bus.sram_addr  = addr_q;
    assign bus.sram_dq_o  = wdata_q;
    assign bus.sram_dq_oe = dq_oe_q;
    assign bus.sram_ce_n  = ce_n_q;
    assign bus.sram_oe_n  = oe_n_q;
    assign bus.sram_we_n  = we_n_q;

endmodule

// File: doc/mem_access_arbiter.md
MEM_ACCESS_ARBITER -- requirements
Module: mem_access_arbiter

Interface
REQ-001 clock  in  1  single system clock; all state updates on its rising edge.
REQ-002 reset  in  1  synchronous, active-high reset, sampled on rising clock.
REQ-003 if_req  in  1  fetch-stage read request; held until if_ack.
REQ-004 if_addr  in  16  fetch address (current program counter).
REQ-005 if_rdata  out  16  fetched instruction; valid while if_ack=1.
REQ-006 if_ack  out  1  one-cycle fetch-complete pulse.
REQ-007 dm_req  in  1  memory-stage request; held until dm_ack.
REQ-008 dm_we  in  1  1=store (SW, SW_SP), 0=load (LW, LW_SP).
REQ-009 dm_addr  in  16  data address produced by the ALU target value.
REQ-010 dm_wdata  in  16  store data.
REQ-011 dm_rdata  out  16  load data; valid while dm_ack=1.
REQ-012 dm_ack  out  1  one-cycle data-complete pulse.
REQ-013 stall_if  out  1  freezes PC/IF-ID while fetch is pending or blocked.
REQ-014 sram_addr  out  16  shared SRAM address.
REQ-015 sram_dq_o / sram_dq_oe / sram_dq_i  out/out/in  16/1/16  split bidirectional data bus; drive only when sram_dq_oe=1.
REQ-016 sram_ce_n / sram_oe_n / sram_we_n  out  1 each  active-low SRAM strobes.

Function
REQ-017 States SHALL be IDLE, RD_ACCESS, RD_DONE, WR_SETUP, WR_PULSE, WR_HOLD.
REQ-018 In IDLE, a pending dm_req SHALL win over if_req (fixed data priority); the winner's port, address, we and wdata SHALL be latched at the grant edge.
REQ-019 Grant with read -> RD_ACCESS: sram_addr=latched addr, ce_n=0, oe_n=0, we_n=1, dq_oe=0; sram_dq_i captured at end of cycle.
REQ-020 RD_DONE: strobes inactive; granted port's ack=1 and rdata=captured word; then IDLE.
REQ-021 Grant with write -> WR_SETUP (ce_n=0, we_n=1, dq_oe=1, addr/data stable), WR_PULSE (we_n=0), WR_HOLD (we_n=1, dq_oe=1, dm_ack=1); then IDLE.
REQ-022 Latency from grant edge: read ack in 2nd cycle, write ack in 3rd cycle; one IDLE cycle SHALL separate consecutive transactions.
REQ-023 Address and data SHALL remain stable from WR_SETUP through WR_HOLD; we_n SHALL never fall while dq_oe=0.
REQ-024 Changes to request inputs after grant SHALL be ignored until return to IDLE; dropping req mid-transaction SHALL NOT abort it.
REQ-025 stall_if SHALL equal if_req AND NOT if_ack (high during fetch wait, including while data holds the bus).
REQ-026 if_ack and dm_ack SHALL never be high in the same cycle; outputs SHALL be registered.
REQ-027 Simultaneous if_req and dm_req in IDLE: data first, fetch granted in the next IDLE cycle.

Reset
REQ-028 On reset: state=IDLE, ce_n=oe_n=we_n=1, dq_oe=0, both acks 0, rdata registers 0x0000, sram_addr 0x0000.
REQ-029 Reset asserted mid-transaction SHALL abandon it without ack and deassert we_n/dq_oe at that same edge.

Structure
REQ-030 State encoding and strobe-level constants SHALL live in the shared constants package alongside the existing opcode constants.
REQ-031 Single flat module; no sub-module required.

Verification
REQ-032 Reset, then if_req=1, if_addr=0x0004, SRAM[0x0004]=0x6801 -> if_ack with if_rdata=0x6801 two cycles after grant; stall_if high until then.
REQ-033 dm_req, dm_we=1, dm_addr=0xBF00, dm_wdata=0x1234 -> we_n low exactly one cycle (WR_PULSE), dm_ack in WR_HOLD; subsequent load of 0xBF00 returns 0x1234.
REQ-034 if_req and dm_req (load 0x0010=0xBEEF) in same cycle -> dm_ack/0xBEEF first; if_ack follows after one IDLE; acks never overlap.
REQ-035 Reset asserted in WR_PULSE -> next edge we_n=1, dq_oe=0, state IDLE, no dm_ack.
REQ-036 dm_req dropped one cycle after grant -> transaction completes, dm_ack still pulsed once.
